// File: rtl/vm2002_common_pkg.sv
// vm2002_common_pkg: shared coin type, coin values and the change-dispenser state encoding
package vm2002_common_pkg;
  typedef enum logic [1:0] {COIN_NONE = 2'd0, NICKEL = 2'd1, DIME = 2'd2, QUARTER = 2'd3} coins_t;
  localparam int NICKEL_CENTS = 5;
  localparam int DIME_CENTS = 10;
  localparam int QUARTER_CENTS = 25;
  typedef enum int {CS_IDLE_I = 0, CS_SELECT_I = 1, CS_ISSUE_I = 2} change_state_idx_t;
  typedef enum logic [2:0] {CS_IDLE = 3'b001, CS_SELECT = 3'b010, CS_ISSUE = 3'b100} change_state_t;
  function automatic int coin_value(coins_t c);
    return c == QUARTER ? QUARTER_CENTS : c == DIME ? DIME_CENTS : c == NICKEL ? NICKEL_CENTS : 0;
  endfunction
endpackage

// File: rtl/vm2002_change_dispenser_if.sv
// vm2002_change_dispenser_if: change request, coin stream and inventory signals of the dispenser
interface vm2002_change_dispenser_if import vm2002_common_pkg::*; #(
  parameter int COIN_CNT_W = 4,
  parameter int AMT_W = 8
);
  logic                  change_req;
  logic [AMT_W-1:0]      change_amt;
  logic                  change_ack;
  logic                  coin_valid;
  coins_t                coin_out;
  logic                  coin_ready;
  logic                  change_done;
  logic                  change_short;
  logic [AMT_W-1:0]      short_amt;
  logic                  busy;
  logic                  refill;
  logic [COIN_CNT_W-1:0] refill_q, refill_d, refill_n;
  logic [COIN_CNT_W-1:0] q_cnt, d_cnt, n_cnt;
  modport slave (
    input  change_req, change_amt, coin_ready, refill, refill_q, refill_d, refill_n,
    output change_ack, coin_valid, coin_out, change_done, change_short, short_amt, busy,
           q_cnt, d_cnt, n_cnt
  );
  modport master (
    output change_req, change_amt, coin_ready, refill, refill_q, refill_d, refill_n,
    input  change_ack, coin_valid, coin_out, change_done, change_short, short_amt, busy,
           q_cnt, d_cnt, n_cnt
  );
endinterface

// File: rtl/vm2002_coin_select.sv
// vm2002_coin_select: greedy picker, largest coin that fits the remainder and is in stock
module vm2002_coin_select import vm2002_common_pkg::*; #(
  parameter int COIN_CNT_W = 4,
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0]      i_rem,
  input  logic [COIN_CNT_W-1:0] i_q_cnt,
  input  logic [COIN_CNT_W-1:0] i_d_cnt,
  input  logic [COIN_CNT_W-1:0] i_n_cnt,
  output coins_t                o_coin,
  output logic                  o_coin_found,
  output logic [AMT_W-1:0]      o_coin_val
);
  logic w_q, w_d, w_n;
  // first match wins: quarter, then dime, then nickel
  always_comb begin
    w_q = i_rem >= AMT_W'(QUARTER_CENTS) && i_q_cnt != '0;
    w_d = i_rem >= AMT_W'(DIME_CENTS) && i_d_cnt != '0;
    w_n = i_rem >= AMT_W'(NICKEL_CENTS) && i_n_cnt != '0;
    o_coin = w_q ? QUARTER : w_d ? DIME : w_n ? NICKEL : COIN_NONE;
    o_coin_found = w_q | w_d | w_n;
    o_coin_val = AMT_W'(coin_value(o_coin));
  end
endmodule

// File: rtl/vm2002_change_dispenser.sv
// vm2002_change_dispenser: returns change as a greedy coin stream and tracks coin inventory.
// Define VM2002_CHANGE_STATS_EN to add the saturating cents_returned accumulator output.
module vm2002_change_dispenser import vm2002_common_pkg::*; #(
  parameter int COIN_CNT_W = 4,
  parameter int AMT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  vm2002_change_dispenser_if.slave bus
`ifdef VM2002_CHANGE_STATS_EN
  ,
  output logic [15:0] cents_returned
`endif
);
  change_state_t         r_state, w_next;
  logic [AMT_W-1:0]      r_rem, r_short_amt, w_sel_val, w_iss_val;
  logic [COIN_CNT_W-1:0] r_q, r_d, r_n, w_q_sat, w_d_sat, w_n_sat;
  logic [COIN_CNT_W:0]   w_q_sum, w_d_sum, w_n_sum;
  coins_t                r_coin, w_sel_coin;
  logic                  r_ack, r_done, r_short, w_found, w_accept, w_refill, w_take;

  vm2002_coin_select #(.COIN_CNT_W(COIN_CNT_W), .AMT_W(AMT_W)) u_sel (
    .i_rem(r_rem), .i_q_cnt(r_q), .i_d_cnt(r_d), .i_n_cnt(r_n),
    .o_coin(w_sel_coin), .o_coin_found(w_found), .o_coin_val(w_sel_val)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= CS_IDLE;
    else r_state <= w_next;

  // next state, handshake qualifiers and saturating refill sums
  always_comb begin
    w_accept = r_state[CS_IDLE_I] && bus.change_req;
    w_refill = r_state[CS_IDLE_I] && bus.refill && !bus.change_req;
    w_take = r_state[CS_ISSUE_I] && bus.coin_ready;
    w_iss_val = AMT_W'(coin_value(r_coin));
    w_q_sum = {1'b0, r_q} + {1'b0, bus.refill_q};
    w_d_sum = {1'b0, r_d} + {1'b0, bus.refill_d};
    w_n_sum = {1'b0, r_n} + {1'b0, bus.refill_n};
    w_q_sat = w_q_sum[COIN_CNT_W] ? '1 : w_q_sum[COIN_CNT_W-1:0];
    w_d_sat = w_d_sum[COIN_CNT_W] ? '1 : w_d_sum[COIN_CNT_W-1:0];
    w_n_sat = w_n_sum[COIN_CNT_W] ? '1 : w_n_sum[COIN_CNT_W-1:0];
    w_next = r_state[CS_IDLE_I] ? (bus.change_req ? CS_SELECT : CS_IDLE) :
             r_state[CS_SELECT_I] ? (w_found ? CS_ISSUE : CS_IDLE) :
             r_state[CS_ISSUE_I] ? (bus.coin_ready ? CS_SELECT : CS_ISSUE) : CS_IDLE;
  end

  // outputs: busy and coin_valid follow the state, the rest are registers
  always_comb begin
    bus.busy = !r_state[CS_IDLE_I];
    bus.coin_valid = r_state[CS_ISSUE_I];
    bus.coin_out = r_coin;
    bus.change_ack = r_ack;
    bus.change_done = r_done;
    bus.change_short = r_short;
    bus.short_amt = r_short_amt;
    bus.q_cnt = r_q;
    bus.d_cnt = r_d;
    bus.n_cnt = r_n;
  end

  // remainder, chosen coin, status pulses and inventory
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem <= '0;
      r_short_amt <= '0;
      r_coin <= COIN_NONE;
      r_ack <= 1'b0;
      r_done <= 1'b0;
      r_short <= 1'b0;
      r_q <= '0;
      r_d <= '0;
      r_n <= '0;
    end else begin
      r_ack <= w_accept;
      r_done <= r_state[CS_SELECT_I] && !w_found && r_rem == '0;
      r_short <= r_state[CS_SELECT_I] && !w_found && r_rem != '0;
      if (w_accept) begin
        r_rem <= bus.change_amt;
        r_short_amt <= '0;
      end
      if (r_state[CS_SELECT_I] && !w_found && r_rem != '0) r_short_amt <= r_rem;
      if (r_state[CS_SELECT_I] && w_found) r_coin <= w_sel_coin;
      if (w_refill) begin
        r_q <= w_q_sat;
        r_d <= w_d_sat;
        r_n <= w_n_sat;
      end
      if (w_take) begin
        r_rem <= r_rem - w_iss_val;
        r_q <= r_q - COIN_CNT_W'(r_coin == QUARTER);
        r_d <= r_d - COIN_CNT_W'(r_coin == DIME);
        r_n <= r_n - COIN_CNT_W'(r_coin == NICKEL);
      end
    end

`ifdef VM2002_CHANGE_STATS_EN
  logic [15:0] r_cents;
  logic [16:0] w_cents_sum;
  // running total of handshaken coin value
  always_comb begin
    w_cents_sum = {1'b0, r_cents} + 17'(w_iss_val);
    cents_returned = r_cents;
  end
  // saturating accumulate on each handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cents <= '0;
    else if (w_take) r_cents <= w_cents_sum[16] ? 16'hFFFF : w_cents_sum[15:0];
`endif
endmodule

// File: doc/vm2002_change_dispenser.md
# vm2002_change_dispenser

Coin-return engine for the vm2002 vending machine: the transmit end of the coin interface that the main FSM receives on. It accepts a change amount in cents from the vending-machine FSM and emits a sequence of `coins_t` coins (QUARTER, DIME, NICKEL) to the coin-ejector mechanism over a valid/ready handshake. It tracks per-denomination coin inventory and reports any shortfall.

## Interface
- `COIN_CNT_W`, default 4: width of each inventory counter (matches the item count width).
- `AMT_W`, default 8: width of amounts in cents (matches the item cost width).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `change_req` in 1: request to return `change_amt`; sampled only in IDLE.
- `change_amt` in AMT_W: cents to return.
- `change_ack` out 1: one-cycle pulse, request accepted.
- `coin_valid` out 1: `coin_out` holds a coin for the ejector.
- `coin_out` out 2 (`coins_t`): coin being ejected.
- `coin_ready` in 1: ejector takes the coin on `coin_valid && coin_ready`.
- `change_done` out 1: one-cycle pulse, full amount returned.
- `change_short` out 1: one-cycle pulse, amount could not be fully returned.
- `short_amt` out AMT_W: unreturned cents; valid with `change_short`, held until the next request is accepted.
- `busy` out 1: state is not IDLE.
- `refill` in 1: add `refill_q/d/n` to the inventory; honoured only in IDLE.
- `refill_q`, `refill_d`, `refill_n` in COIN_CNT_W: coins added per denomination.
- `q_cnt`, `d_cnt`, `n_cnt` out COIN_CNT_W: current inventory.

## Operation
- States (one-hot, shared-package typedef): IDLE, SELECT, ISSUE.
- **IDLE**
  - `change_req` has priority over `refill`; a simultaneous `refill` is dropped.
  - On `change_req`: latch `rem <= change_amt`, pulse `change_ack`, clear `short_amt`, go to SELECT.
  - On `refill` alone: each count becomes min(count + refill_x, 2^COIN_CNT_W−1), saturating.
- **SELECT** uses greedy selection, first match wins:
  - `rem>=25 && q_cnt>0` gives QUARTER.
  - else `rem>=10 && d_cnt>0` gives DIME.
  - else `rem>=5 && n_cnt>0` gives NICKEL.
  - If a coin is chosen: register `coin_out`, set `coin_valid`, go to ISSUE.
  - Else if `rem==0`: pulse `change_done`, go to IDLE.
  - Else: pulse `change_short` with `short_amt <= rem`, go to IDLE. This includes a non-multiple-of-5 residue.
- **ISSUE**
  - Hold `coin_valid` and `coin_out` stable until `coin_ready`.
  - On the handshake edge, decrement that denomination's count, subtract the coin value from `rem`, drop `coin_valid`, and go to SELECT.
- Greedy is required even where another coin mix would succeed. Subtraction cannot underflow because each coin is chosen only when `rem >= value`.
- `refill` and `change_req` outside IDLE are ignored. They are not queued.

## Timing
- Reset (asynchronous, immediate):
  - State is IDLE.
  - All pulses, `coin_valid` and `busy` are 0.
  - `coin_out` is 2'h0 and `short_amt` is 0.
  - All inventory counts and `rem` are 0.
- Reset mid-dispense abandons the transaction and clears inventory. No partial status is reported.
- Request sampled at edge N: `change_ack` and `busy` are high in cycle N+1, and `coin_valid` rises at N+2 if a coin is available.
- Each coin takes at least 2 cycles (SELECT plus ISSUE). Back-to-back coins are possible with `coin_ready` tied high.
- The `change_done` or `change_short` pulse coincides with the return to IDLE. A new `change_req` can be accepted in that same cycle.
- `change_amt==0` produces `change_done` at N+2 with no coins.

## Configuration
- `VM2002_CHANGE_STATS_EN`
  - Defined: adds output `cents_returned` (16 bits), which accumulates the value of every handshaken coin and saturates at 16'hFFFF. It is reset to 0.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Added to `vm2002_common_pkg`:
  - `change_state_t`, one-hot typedef with its index enum.
  - Constants `NICKEL_CENTS=5`, `DIME_CENTS=10`, `QUARTER_CENTS=25`.
  - `coins_t` is reused from the package.
- Sub-module `vm2002_coin_select`: combinational greedy picker. It takes `rem` and the three counts, and outputs the coin, `coin_found` and the coin value.

## Test plan
- Refill q=2, d=2, n=2, then request 40 -> QUARTER, DIME, NICKEL, then `change_done`; counts become q=1, d=1, n=1.
- Inventory q=1, d=3, n=0, request 30 -> QUARTER, then `change_short` with `short_amt=5`. This confirms greedy even though three dimes would succeed.
- Request 0 -> `change_ack`, then `change_done` at N+2 with no `coin_valid`.
- Hold `coin_ready` low for 5 cycles during a QUARTER -> `coin_out` stays stable and counts are unchanged until the handshake.
- Refill n=10 twice -> `n_cnt=15` (saturated). Refill while busy -> ignored.
- Assert `rst_n` low mid-ISSUE -> `coin_valid` is 0 immediately and all counts are 0. With `VM2002_CHANGE_STATS_EN` defined, a prior 40-cent return shows `cents_returned=40` before the reset.
